// File: rtl/my_3_8_decoder.sv
// rtl/my_3_8_decoder.sv - registered 3-to-8 line decoder with selectable output polarity
module my_3_8_decoder #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] out,
    output logic       valid,
    output logic [2:0] idx
);

    // Pattern driven when nothing is selected; also the reset value of out.
    localparam logic [7:0] INACTIVE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    // All-ones when the build is active-low, so XOR flips the active-high decode.
    localparam logic [7:0] POLARITY_MASK = {8{OUT_ACTIVE_LOW}};

    logic [2:0] sel;
    logic [7:0] onehot;

    logic [7:0] out_d,   out_q;
    logic       valid_d, valid_q;
    logic [2:0] idx_d,   idx_q;

    assign sel = {a, b, c};

    // Active-high one-hot decode of the current select.
    always_comb begin
        onehot      = 8'h00;
        onehot[sel] = 1'b1;
    end

    // Next-state: decode when enabled, otherwise go inactive while idx keeps the last select.
    always_comb begin
        out_d   = INACTIVE;
        valid_d = 1'b0;
        idx_d   = idx_q;
        if (en) begin
            out_d   = onehot ^ POLARITY_MASK;
            valid_d = 1'b1;
            idx_d   = sel;
        end
    end

    // Output registers; asynchronous reset forces the inactive state without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= INACTIVE;
            valid_q <= 1'b0;
            idx_q   <= 3'b000;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign idx   = idx_q;

endmodule

// File: tb/tb_my_3_8_decoder.sv
// tb/tb_my_3_8_decoder.sv - directed and randomised checks of my_3_8_decoder in both polarities
module tb_my_3_8_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       a;
    logic       b;
    logic       c;
    logic [7:0] out_hi;
    logic       valid_hi;
    logic [2:0] idx_hi;
    logic [7:0] out_lo;
    logic       valid_lo;
    logic [2:0] idx_lo;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_tab [8];
    logic [7:0] m_out;
    logic       m_valid;
    logic [2:0] m_idx;

    my_3_8_decoder #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .out(out_hi), .valid(valid_hi), .idx(idx_hi)
    );

    my_3_8_decoder #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
        .out(out_lo), .valid(valid_lo), .idx(idx_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_valid,
                           input logic [2:0] e_idx);
        chk({tag, "_out_hi"}, out_hi, e_out);
        chk({tag, "_out_lo"}, out_lo, ~e_out);
        chk({tag, "_valid_hi"}, {7'b0, valid_hi}, {7'b0, e_valid});
        chk({tag, "_valid_lo"}, {7'b0, valid_lo}, {7'b0, e_valid});
        chk({tag, "_idx_hi"}, {5'b0, idx_hi}, {5'b0, e_idx});
        chk({tag, "_idx_lo"}, {5'b0, idx_lo}, {5'b0, e_idx});
    endtask

    task automatic set_sel(input logic [2:0] s);
        {a, b, c} = s;
    endtask

    // Wait for the next rising edge and step 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_tab[0] = 8'h01; exp_tab[1] = 8'h02; exp_tab[2] = 8'h04; exp_tab[3] = 8'h08;
        exp_tab[4] = 8'h10; exp_tab[5] = 8'h20; exp_tab[6] = 8'h40; exp_tab[7] = 8'h80;

        rst = 1'b1;
        en  = 1'b0;
        set_sel(3'b000);
        #2;
        chk_all("reset_initial", 8'h00, 1'b0, 3'd0);

        tick();
        chk_all("reset_held_edge", 8'h00, 1'b0, 3'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Exhaustive sweep, each select held for 10 cycles.
        for (int s = 0; s < 8; s++) begin
            set_sel(3'(s));
            for (int k = 0; k < 10; k++) begin
                tick();
                chk_all($sformatf("sweep_s%0d_k%0d", s, k), exp_tab[s], 1'b1, 3'(s));
            end
        end

        // Latency: a select change between edges must not reach out until the next edge.
        set_sel(3'b011);
        tick();
        chk_all("lat_before", 8'h08, 1'b1, 3'd3);
        set_sel(3'b110);
        #3;
        chk_all("lat_no_comb_path", 8'h08, 1'b1, 3'd3);
        tick();
        chk_all("lat_after_edge", 8'h40, 1'b1, 3'd6);

        // Enable gating: idx must keep the last decoded select while en=0.
        set_sel(3'b011);
        tick();
        chk_all("en_prime", 8'h08, 1'b1, 3'd3);
        en = 1'b0;
        set_sel(3'b101);
        tick();
        chk_all("en_low", 8'h00, 1'b0, 3'd3);
        tick();
        chk_all("en_low_hold", 8'h00, 1'b0, 3'd3);
        en = 1'b1;
        tick();
        chk_all("en_high_again", 8'h20, 1'b1, 3'd5);

        // Asynchronous reset between edges while out=8'h20.
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_reset_immediate", 8'h00, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            set_sel(3'(k + 2));
            tick();
            chk_all($sformatf("reset_held_%0d", k), 8'h00, 1'b0, 3'd0);
        end
        set_sel(3'b010);
        rst = 1'b0;
        #2;
        chk_all("reset_release_no_edge", 8'h00, 1'b0, 3'd0);
        tick();
        chk_all("first_decode_after_release", 8'h04, 1'b1, 3'd2);
        chk("active_low_010", out_lo, 8'hFB);
        set_sel(3'b111);
        tick();
        chk("active_low_111", out_lo, 8'h7F);
        chk("active_high_111", out_hi, 8'h80);

        // Random run against a reference model plus the one-hot invariant.
        m_out   = out_hi;
        m_valid = valid_hi;
        m_idx   = idx_hi;
        for (int i = 0; i < 1000; i++) begin
            rst = ($urandom_range(0, 29) == 0);
            en  = ($urandom_range(0, 3) != 0);
            set_sel(3'($urandom_range(0, 7)));
            if (rst) begin
                m_out = 8'h00; m_valid = 1'b0; m_idx = 3'd0;
                #1;
                chk_all($sformatf("rnd_async_rst_%0d", i), m_out, m_valid, m_idx);
            end
            @(posedge clk);
            if (rst) begin
                m_out = 8'h00; m_valid = 1'b0; m_idx = 3'd0;
            end else if (en) begin
                m_idx   = {a, b, c};
                m_out   = exp_tab[m_idx];
                m_valid = 1'b1;
            end else begin
                m_out   = 8'h00;
                m_valid = 1'b0;
            end
            #1;
            chk_all($sformatf("rnd_%0d", i), m_out, m_valid, m_idx);
            if (valid_hi) begin
                chk($sformatf("inv_popcnt_%0d", i), 8'($countones(out_hi)), 8'd1);
                chk($sformatf("inv_bit_at_idx_%0d", i), {7'b0, out_hi[idx_hi]}, 8'd1);
                chk($sformatf("inv_lo_zero_at_idx_%0d", i), {7'b0, out_lo[idx_lo]}, 8'd0);
            end else begin
                chk($sformatf("inv_idle_hi_%0d", i), out_hi, 8'h00);
                chk($sformatf("inv_idle_lo_%0d", i), out_lo, 8'hFF);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
